// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: serial taps fill a shadow bank, which is
// copied atomically into the registered active bank when downstream allows.
module fir_coeff_loader #(
    parameter int BITWIDTH   = 16,
    parameter int N          = 16,
    parameter int INIT_UNITY = 0,
    parameter int CNTWIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [BITWIDTH-1:0]     s_data,
    input  logic                    s_last,
    input  logic                    swap_en,
    output logic [N*BITWIDTH-1:0]   coeffs,
    output logic                    busy,
    output logic                    loaded,
    output logic                    err,
    output logic [CNTWIDTH-1:0]     load_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [N*BITWIDTH-1:0] INIT_BANK =
        (INIT_UNITY != 0) ? {{(N*BITWIDTH-1){1'b0}}, 1'b1} : '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BITWIDTH-1:0]    shadow_q [N];
    logic [BITWIDTH-1:0]    shadow_d [N];
    logic [N*BITWIDTH-1:0]  coeffs_q, coeffs_d;
    logic                   loaded_q, loaded_d;
    logic                   err_q, err_d;
    logic [CNTWIDTH-1:0]    cnt_q, cnt_d;
    logic                   accept;

    assign s_ready    = (state_q != PEND);
    assign busy       = (state_q != IDLE);
    assign accept     = s_valid && s_ready;
    assign coeffs     = coeffs_q;
    assign loaded     = loaded_q;
    assign err        = err_q;
    assign load_count = cnt_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        coeffs_d = coeffs_q;
        cnt_d    = cnt_q;
        loaded_d = 1'b0;
        err_d    = 1'b0;

        if (accept) begin
            shadow_d[idx_q] = s_data;
        end

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = PEND;
                        end else begin
                            // Missing last: drop the set, stay ready.
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            PEND: begin
                if (swap_en) begin
                    for (int i = 0; i < N; i++) begin
                        coeffs_d[i*BITWIDTH +: BITWIDTH] = shadow_q[i];
                    end
                    cnt_d    = cnt_q + 1'b1;
                    loaded_d = 1'b1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            coeffs_q <= INIT_BANK;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            coeffs_q <= coeffs_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Shadow contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a scoreboard of expected
// coefficient banks popped on every loaded pulse.
module tb_fir_coeff_loader;

    localparam int BW = 16;
    localparam int NT = 16;
    localparam int CW = 8;
    localparam int TW = NT * BW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          s_last;
    logic          swap_en;
    logic [TW-1:0] coeffs;
    logic          busy;
    logic          loaded;
    logic          err;
    logic [CW-1:0] load_count;

    fir_coeff_loader #(
        .BITWIDTH  (BW),
        .N         (NT),
        .INIT_UNITY(1),
        .CNTWIDTH  (CW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .swap_en   (swap_en),
        .coeffs    (coeffs),
        .busy      (busy),
        .loaded    (loaded),
        .err       (err),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    localparam logic [TW-1:0] UNITY = {{(TW-1){1'b0}}, 1'b1};

    int            errors = 0;
    int            checks = 0;
    logic [BW-1:0] set_v [NT];
    logic [TW-1:0] sb_q [$];
    logic [TW-1:0] active;
    logic [CW-1:0] exp_cnt;

    task automatic chk(string tag, logic [TW-1:0] obs, logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] pack_set();
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < NT; i++) r[i*BW +: BW] = set_v[i];
        return r;
    endfunction

    // Drive nbeats from set_v; s_last on beat index last_at (-1 = never).
    task automatic send(int nbeats, int last_at, bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    s_valid = 1'b0;
                    s_data  = $urandom();
                    s_last  = $urandom_range(0, 1);
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data  = set_v[i];
            s_last  = (i == last_at);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_full(bit gaps);
        sb_q.push_back(pack_set());
        send(NT, NT - 1, gaps);
        chk("pend_ready", s_ready, 0);
        chk("pend_busy", busy, 1);
    endtask

    task automatic expect_swap(int max_cyc);
        int n;
        logic [TW-1:0] e;
        n = 0;
        while (loaded !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("loaded_pulse", loaded, 1);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            e = active;
        end else begin
            e = sb_q.pop_front();
        end
        exp_cnt = exp_cnt + 1'b1;
        active  = e;
        chk("coeffs_swap", coeffs, e);
        chk("load_count", load_count, exp_cnt);
        chk("busy_after", busy, 0);
        chk("ready_after", s_ready, 1);
        @(negedge clk);
        chk("loaded_1cyc", loaded, 0);
    endtask

    task automatic check_err_pulse();
        chk("err_pulse", err, 1);
        chk("err_ready", s_ready, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_1cyc", err, 0);
        chk("err_coeffs", coeffs, active);
        chk("err_count", load_count, exp_cnt);
    endtask

    initial begin
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        swap_en = 1'b0;
        exp_cnt = '0;
        active  = UNITY;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // T1 reset state
        chk("rst_coeffs", coeffs, UNITY);
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", load_count, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_err", err, 0);

        // T2 back-to-back set, swap right away
        swap_en = 1'b1;
        for (int i = 0; i < NT; i++) set_v[i] = BW'(i + 1);
        send_full(1'b0);
        chk("t2_hold", coeffs, UNITY);
        expect_swap(1);

        // T3 backpressure while swap_en low
        swap_en = 1'b0;
        for (int i = 0; i < NT; i++) set_v[i] = BW'(16'h8000 + i * 3);
        send_full(1'b0);
        for (int c = 0; c < 10; c++) begin
            chk("t3_ready0", s_ready, 0);
            chk("t3_hold", coeffs, active);
            chk("t3_noload", loaded, 0);
            @(negedge clk);
        end
        swap_en = 1'b1;
        expect_swap(1);

        // T4 early last, then all -1
        for (int i = 0; i < NT; i++) set_v[i] = BW'(16'h1234 + i);
        send(5, 4, 1'b0);
        check_err_pulse();
        for (int i = 0; i < NT; i++) set_v[i] = 16'hFFFF;
        send_full(1'b0);
        expect_swap(1);
        chk("t4_ffff", coeffs, {TW{1'b1}});

        // T5 missing last with gaps, then gapped valid set
        for (int i = 0; i < NT; i++) set_v[i] = BW'($urandom());
        send(NT, -1, 1'b1);
        check_err_pulse();
        for (int i = 0; i < NT; i++) set_v[i] = BW'($urandom());
        send_full(1'b1);
        expect_swap(1);

        // T6 reset mid-load, then wrap load_count
        for (int i = 0; i < NT; i++) set_v[i] = BW'(16'h5A00 + i);
        send(8, -1, 1'b0);
        chk("t6_busy", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn  = 1'b1;
        exp_cnt = '0;
        active  = UNITY;
        chk("t6_coeffs", coeffs, UNITY);
        chk("t6_busy0", busy, 0);
        chk("t6_count", load_count, 0);
        chk("t6_ready", s_ready, 1);
        for (int i = 0; i < NT; i++) set_v[i] = BW'(16'h7000 - i);
        send_full(1'b0);
        expect_swap(1);
        for (int s = 0; s < 255; s++) begin
            for (int i = 0; i < NT; i++) set_v[i] = BW'(s * 37 + i * 1031);
            send_full(1'b0);
            expect_swap(1);
        end
        chk("t6_wrap", load_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
